// File: rtl/ctrl_cfg_pkt_gen.sv
// ---------------------------------------------------------------------------
// ctrl_cfg_pkt_gen
//
// Transmit side of the stage control path. A local host writes one VLAN
// page-table entry per request; each accepted request becomes a 3-beat
// AXI-Stream control packet followed by an idle gap so downstream control
// parsers return to their first-segment state before the next packet.
//
// Beat layout (256-bit tdata):
//   beat 1 : HDR_TDATA / HDR_TUSER (constant Ethernet/IP header beat)
//   beat 2 : [135:128] index, [119:112] {stage, action}, [79:64] 16'hf2f1
//   beat 3 : [15:0] byte-swapped entry value, tlast = 1
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_stage_id        target stage (mod_id[7:3])
//   req_action_id       target module in the stage (mod_id[2:0])
//   req_index           page-table index
//   req_data            page-table entry value
//   c_m_axis_*          control AXI-Stream master (tdata/tuser/tkeep/
//                       tvalid/tlast out, tready in)
//   busy                high from request accept until the gap expires
//   pkt_cnt             (only with CTRL_CFG_PKT_CNT_EN) count of completed
//                       packets, wraps at 2^32
//
// Optional feature macro: CTRL_CFG_PKT_CNT_EN adds the pkt_cnt output.
// All outputs are registered.
// ---------------------------------------------------------------------------
module ctrl_cfg_pkt_gen #(
  parameter int                                C_S_AXIS_DATA_WIDTH  = 256,
  parameter int                                C_S_AXIS_TUSER_WIDTH = 128,
  parameter logic [C_S_AXIS_DATA_WIDTH-1:0]    HDR_TDATA            = '0,
  parameter logic [C_S_AXIS_TUSER_WIDTH-1:0]   HDR_TUSER            = '0,
  parameter int                                GAP_CYCLES           = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  logic [4:0]                           req_stage_id,
  input  logic [2:0]                           req_action_id,
  input  logic [7:0]                           req_index,
  input  logic [15:0]                          req_data,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       c_m_axis_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      c_m_axis_tuser,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     c_m_axis_tkeep,
  output logic                                 c_m_axis_tvalid,
  output logic                                 c_m_axis_tlast,
  input  logic                                 c_m_axis_tready,
  output logic                                 busy
`ifdef CTRL_CFG_PKT_CNT_EN
  ,
  output logic [31:0]                          pkt_cnt
`endif
);

  localparam int KEEP_W = C_S_AXIS_DATA_WIDTH / 8;

  // A zero gap would let a parser see two packets glued together, so the
  // gap is clamped into the 4-bit counter's useful range 1..15.
  localparam int GAP_EFF = (GAP_CYCLES < 1)  ? 1  :
                           (GAP_CYCLES > 15) ? 15 : GAP_CYCLES;
  localparam logic [3:0] GAP_LOAD = 4'(GAP_EFF);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT1 = 3'd1,
    BEAT2 = 3'd2,
    BEAT3 = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t                              state_q, state_d;
  logic [3:0]                          gap_cnt_q, gap_cnt_d;
  logic                                req_ready_q, req_ready_d;
  logic                                busy_q, busy_d;
  logic                                tvalid_q, tvalid_d;
  logic                                tlast_q, tlast_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]      tdata_q, tdata_d;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]     tuser_q, tuser_d;
  logic [KEEP_W-1:0]                   tkeep_q, tkeep_d;
  logic [4:0]                          stage_q, stage_d;
  logic [2:0]                          action_q, action_d;
  logic [7:0]                          index_q, index_d;
  logic [15:0]                         data_q, data_d;
  logic [C_S_AXIS_DATA_WIDTH-1:0]      beat2_word;
  logic [C_S_AXIS_DATA_WIDTH-1:0]      beat3_word;
  logic                                beat_hs;
`ifdef CTRL_CFG_PKT_CNT_EN
  logic [31:0]                         pkt_cnt_q, pkt_cnt_d;
`endif

  assign beat_hs = tvalid_q & c_m_axis_tready;

  // Payload beats are built from the request latch, never from the live
  // req_* inputs, so changes on the request bus mid-packet have no effect.
  always_comb begin
    beat2_word          = '0;
    beat2_word[112 +: 8] = {stage_q, action_q};
    beat2_word[64 +: 16] = 16'hf2f1;
    beat2_word[128 +: 8] = index_q;
    beat3_word          = '0;
    beat3_word[7:0]     = data_q[15:8];
    beat3_word[15:8]    = data_q[7:0];
  end

  // Next-state logic. Every output register defaults to holding, which is
  // what keeps the bus stable while tready is low.
  always_comb begin
    state_d     = state_q;
    gap_cnt_d   = gap_cnt_q;
    req_ready_d = req_ready_q;
    busy_d      = busy_q;
    tvalid_d    = tvalid_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;
    tuser_d     = tuser_q;
    tkeep_d     = tkeep_q;
    stage_d     = stage_q;
    action_d    = action_q;
    index_d     = index_q;
    data_d      = data_q;
`ifdef CTRL_CFG_PKT_CNT_EN
    pkt_cnt_d   = pkt_cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          stage_d     = req_stage_id;
          action_d    = req_action_id;
          index_d     = req_index;
          data_d      = req_data;
          req_ready_d = 1'b0;
          busy_d      = 1'b1;
          tvalid_d    = 1'b1;
          tdata_d     = HDR_TDATA;
          tuser_d     = HDR_TUSER;
          tkeep_d     = '1;
          tlast_d     = 1'b0;
          state_d     = BEAT1;
        end
      end

      BEAT1: begin
        if (beat_hs) begin
          tdata_d = beat2_word;
          tuser_d = '0;
          state_d = BEAT2;
        end
      end

      BEAT2: begin
        if (beat_hs) begin
          tdata_d = beat3_word;
          tlast_d = 1'b1;
          state_d = BEAT3;
        end
      end

      BEAT3: begin
        if (beat_hs) begin
          tvalid_d  = 1'b0;
          tlast_d   = 1'b0;
          tdata_d   = '0;
          tkeep_d   = '0;
          gap_cnt_d = GAP_LOAD;
          state_d   = GAP;
`ifdef CTRL_CFG_PKT_CNT_EN
          pkt_cnt_d = pkt_cnt_q + 32'd1;
`endif
        end
      end

      GAP: begin
        // Leaving as the counter hits zero; the <= also recovers from a
        // counter that somehow reads zero on entry.
        if (gap_cnt_q <= 4'd1) begin
          gap_cnt_d   = 4'd0;
          req_ready_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: begin
        tvalid_d    = 1'b0;
        tlast_d     = 1'b0;
        req_ready_d = 1'b1;
        busy_d      = 1'b0;
        gap_cnt_d   = 4'd0;
        state_d     = IDLE;
      end
    endcase
  end

  // Single register bank for the FSM, its outputs and the request latch.
  // Reset aborts any packet in flight: tvalid drops without a tlast beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      gap_cnt_q   <= 4'd0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= '0;
      tuser_q     <= '0;
      tkeep_q     <= '0;
      stage_q     <= '0;
      action_q    <= '0;
      index_q     <= '0;
      data_q      <= '0;
`ifdef CTRL_CFG_PKT_CNT_EN
      pkt_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      gap_cnt_q   <= gap_cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      tvalid_q    <= tvalid_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tkeep_q     <= tkeep_d;
      stage_q     <= stage_d;
      action_q    <= action_d;
      index_q     <= index_d;
      data_q      <= data_d;
`ifdef CTRL_CFG_PKT_CNT_EN
      pkt_cnt_q   <= pkt_cnt_d;
`endif
    end
  end

  assign req_ready       = req_ready_q;
  assign busy            = busy_q;
  assign c_m_axis_tvalid = tvalid_q;
  assign c_m_axis_tlast  = tlast_q;
  assign c_m_axis_tdata  = tdata_q;
  assign c_m_axis_tuser  = tuser_q;
  assign c_m_axis_tkeep  = tkeep_q;
`ifdef CTRL_CFG_PKT_CNT_EN
  assign pkt_cnt         = pkt_cnt_q;
`endif

endmodule
